// File: rtl/data_register.sv
// data_register: clocked WIDTH-bit storage register with per-byte write
// strobes, synchronous clear and a sticky "written" status flag.
// Optional feature macro: DATA_REGISTER_BYPASS_EN. When it is defined, a
// pending write is forwarded combinationally to out, giving write-through
// in the same cycle. When it is undefined, out is purely registered.
module data_register #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic                 regWrite,
  input  logic [WIDTH/8-1:0]   byteEn,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 written
);

  localparam int LANES = WIDTH / 8;

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic             written_reg;
  logic             write_hit;

  // A write only counts when at least one lane is strobed.
  assign write_hit = regWrite && (byteEn != '0);

  // Per-lane merge: new byte on strobed lanes, stored byte elsewhere.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign data_next[8*gi +: 8] = byteEn[gi] ? in[8*gi +: 8] : data_reg[8*gi +: 8];
    end
  endgenerate

  // Storage and sticky flag. Clear beats write. When no write is taken,
  // `in` is never sampled, so X/Z on it cannot reach the stored value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg    <= RESET_VALUE;
      written_reg <= 1'b0;
    end else if (clear) begin
      data_reg    <= RESET_VALUE;
      written_reg <= 1'b0;
    end else if (write_hit) begin
      data_reg    <= data_next;
      written_reg <= 1'b1;
    end
  end

`ifdef DATA_REGISTER_BYPASS_EN
  // Write-through. Reset and clear force the reset value. A pending write
  // shows the merged value. Otherwise out shows the stored value.
  assign out = (reset || clear) ? RESET_VALUE
             : (write_hit ? data_next : data_reg);
`else
  // Purely registered output, with a write latency of one cycle.
  assign out = data_reg;
`endif

  assign written = written_reg;

endmodule

// File: tb/tb_data_register.sv
// tb_data_register: directed testbench for data_register. Each step pushes
// the result it expects into a scoreboard queue. The queue entry is popped
// and compared when the output is sampled, 1 time unit after the clock edge.
`timescale 1ns/1ps
module tb_data_register;

  logic        clk;
  logic        reset;
  logic [31:0] in;
  logic        regWrite;
  logic [3:0]  byteEn;
  logic        clear;
  logic [31:0] out;
  logic        written;

  data_register #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
    .clk(clk), .reset(reset), .in(in), .regWrite(regWrite),
    .byteEn(byteEn), .clear(clear), .out(out), .written(written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] tag;
    logic [31:0]  exp_out;
    logic         exp_written;
  } sb_item_t;

  sb_item_t sb[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic push_exp(input logic [127:0] tag, input logic [31:0] o, input logic w);
    sb_item_t it;
    it.tag = tag;
    it.exp_out = o;
    it.exp_written = w;
    sb.push_back(it);
  endtask

  task automatic pop_check();
    sb_item_t it;
    total_cnt++;
    assert (sb.size() > 0) pass_cnt++;
    else $error("FAIL scoreboard_empty: size=%0d expected >0", sb.size());
    if (sb.size() > 0) begin
      it = sb.pop_front();
      total_cnt++;
      assert (out === it.exp_out) pass_cnt++;
      else $error("FAIL %s out: got %h expected %h", it.tag, out, it.exp_out);
      total_cnt++;
      assert (written === it.exp_written) pass_cnt++;
      else $error("FAIL %s written: got %b expected %b", it.tag, written, it.exp_written);
    end
  endtask

  task automatic edge_check(input logic [127:0] tag, input logic [31:0] o, input logic w);
    push_exp(tag, o, w);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    reset = 1'b1; in = '0; regWrite = 1'b0; byteEn = '0; clear = 1'b0;

    // Reset state
    @(posedge clk); #1;
    regWrite = 1'b1; byteEn = 4'hF; in = 32'hDEADBEEF;
    edge_check("reset_hold", 32'h0, 1'b0);
    reset = 1'b0; regWrite = 1'b0;
    edge_check("reset_release", 32'h0, 1'b0);

    // Test 1: write zero, then hold against changing / unknown input
    regWrite = 1'b1; byteEn = 4'hF; in = 32'h0;
    edge_check("t1_write0", 32'h0, 1'b1);
    regWrite = 1'b0; in = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) edge_check("t1_hold", 32'h0, 1'b1);
    in = 'x;
    edge_check("hold_x_in", 32'h0, 1'b1);

    // Test 2: full write
    regWrite = 1'b1; byteEn = 4'hF; in = 32'hAAAAAAAA;
`ifdef DATA_REGISTER_BYPASS_EN
    #1;
    push_exp("t2_bypass", 32'hAAAAAAAA, 1'b1);
    pop_check();
`endif
    edge_check("t2_full", 32'hAAAAAAAA, 1'b1);

    // Test 3: partial lane write
    byteEn = 4'b0101; in = 32'h12345678;
    edge_check("t3_lanes", 32'hAA34AA78, 1'b1);

    // Back-to-back writes on consecutive edges
    byteEn = 4'hF; in = 32'h11111111;
    edge_check("b2b_1", 32'h11111111, 1'b1);
    in = 32'h22222222;
    edge_check("b2b_2", 32'h22222222, 1'b1);

    // Test 4: clear wins over write
    clear = 1'b1; in = 32'h55555555;
    edge_check("t4_clear", 32'h0, 1'b0);
    clear = 1'b0; regWrite = 1'b0;
    edge_check("t4_after", 32'h0, 1'b0);

    // Test 5: asynchronous reset mid-cycle overrides a pending write
    regWrite = 1'b1; in = 32'hAAAAAAAA;
    edge_check("t5_load", 32'hAAAAAAAA, 1'b1);
    in = 32'h12345678;
    #3 reset = 1'b1;
    #1;
    push_exp("t5_async", 32'h0, 1'b0);
    pop_check();
    edge_check("t5_in_reset", 32'h0, 1'b0);
    reset = 1'b0; regWrite = 1'b0;
    edge_check("t5_release", 32'h0, 1'b0);

    // Test 6: regWrite with no strobes does nothing
    regWrite = 1'b1; byteEn = 4'h0; in = 32'hFFFFFFFF;
    edge_check("t6_nostrobe", 32'h0, 1'b0);
    edge_check("t6_nostrobe2", 32'h0, 1'b0);

    // Written is sticky across a later hold
    byteEn = 4'b1000; in = 32'hC3000000;
    edge_check("sticky_set", 32'hC3000000, 1'b1);
    regWrite = 1'b0;
    edge_check("sticky_hold", 32'hC3000000, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
